// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the triple-buffer frame scheduler.
package frame_buf_pkg;

  localparam int unsigned NUM_BUFS = 3;
  localparam int unsigned IDX_W    = 2;

  typedef logic [IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_RST    = 2'd1,
    W_ACTIVE = 2'd2,
    W_DONE   = 2'd3
  } wr_state_t;

  // Lowest buffer index that is neither the read buffer nor, if valid,
  // the latest complete buffer. With three buffers one is always free.
  function automatic buf_idx_t pick_free(buf_idx_t rd, buf_idx_t lat, logic lat_valid);
    buf_idx_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_BUFS; i++) begin
      if (!found && (buf_idx_t'(i) != rd) && !(lat_valid && (buf_idx_t'(i) == lat))) begin
        r     = buf_idx_t'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fbs_vs_edge.sv
// Level-to-rising-edge pulse detector for a field sync input.
// The pulse is registered, so it appears one cycle after the level is sampled high.
module fbs_vs_edge (
  input  logic i_Sys_clk,
  input  logic i_Rst_n,
  input  logic i_Vs,
  output logic o_Edge
);

  logic vs_prev;

  // Remember the previous level and register the rising-edge compare.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      vs_prev <= 1'b0;
      o_Edge  <= 1'b0;
    end else begin
      vs_prev <= i_Vs;
      o_Edge  <= i_Vs & ~vs_prev;
    end
  end

endmodule

// File: rtl/frame_buf_scheduler.sv
// Triple-buffer scheduler: picks the DDR write buffer per field, issues the
// write-channel reset, and hands the latest complete buffer to the read side.
// Optional: define FBS_DROP_CNT_EN to build the saturating dropped-frame counter.
module frame_buf_scheduler
  import frame_buf_pkg::*;
#(
  parameter int unsigned       AXI_AW       = 32,
  parameter int unsigned       FRAME_PIXELS = 640*480,
  parameter logic [AXI_AW-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter logic [AXI_AW-1:0] FRAME_STRIDE = 32'h0010_0000,
  parameter int unsigned       RST_PERIOD   = 30,
  parameter int unsigned       CNT_W        = 20
) (
  input  logic              i_Sys_clk,
  input  logic              i_Rst_n,
  input  logic              i_Fix_en,
  input  logic              i_Wr_vs,
  input  logic              i_Wr_valid,
  input  logic              i_Rd_vs,
  output logic              o_Wr_rst,
  output logic              o_Wr_req,
  output logic [AXI_AW-1:0] o_Wr_addr,
  output logic [AXI_AW-1:0] o_Rd_addr,
  output logic              o_Rd_new,
  output logic              o_Wr_busy,
  output logic [15:0]       o_Drop_cnt
);

  localparam int unsigned       RC_W      = (RST_PERIOD > 1) ? $clog2(RST_PERIOD) : 1;
  localparam logic [RC_W-1:0]   RST_LAST  = RC_W'(RST_PERIOD - 1);
  localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_PIXELS);
  localparam logic [AXI_AW-1:0] ADDR1     = BASE_ADDR + FRAME_STRIDE;
  localparam logic [AXI_AW-1:0] ADDR2     = BASE_ADDR + (FRAME_STRIDE << 1);

  function automatic logic [AXI_AW-1:0] buf_addr(buf_idx_t idx);
    case (idx)
      2'd1:    return ADDR1;
      2'd2:    return ADDR2;
      default: return BASE_ADDR;
    endcase
  endfunction

  wr_state_t        state, state_nxt;
  buf_idx_t         wr_idx, rd_idx, latest_idx, rd_idx_nxt, sel_idx;
  logic             latest_valid;
  logic [CNT_W-1:0] beat_cnt;
  logic [RC_W-1:0]  rst_cnt;
  logic             wr_edge, rd_edge;
  logic             start, drop, beat_ok;

  fbs_vs_edge u_wr_edge (
    .i_Sys_clk (i_Sys_clk),
    .i_Rst_n   (i_Rst_n),
    .i_Vs      (i_Wr_vs),
    .o_Edge    (wr_edge)
  );

  fbs_vs_edge u_rd_edge (
    .i_Sys_clk (i_Sys_clk),
    .i_Rst_n   (i_Rst_n),
    .i_Vs      (i_Rd_vs),
    .o_Edge    (rd_edge)
  );

  // Next read index, with bypass of the just-completed buffer; the write
  // selection then excludes that next read index.
  always_comb begin
    rd_idx_nxt = rd_idx;
    if (rd_edge) begin
      if (state == W_DONE)   rd_idx_nxt = wr_idx;
      else if (latest_valid) rd_idx_nxt = latest_idx;
    end
    sel_idx = pick_free(rd_idx_nxt, latest_idx, latest_valid);
  end

  // Write FSM next state; a sync edge mid-frame restarts in W_RST as a drop.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    drop      = 1'b0;
    case (state)
      W_IDLE: begin
        if (wr_edge && !i_Fix_en) begin
          state_nxt = W_RST;
          start     = 1'b1;
        end
      end
      W_RST: begin
        if (i_Fix_en) begin
          state_nxt = W_IDLE;
        end else if (wr_edge) begin
          state_nxt = W_RST;
          start     = 1'b1;
          drop      = 1'b1;
        end else if (rst_cnt == RST_LAST) begin
          state_nxt = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (i_Fix_en) begin
          state_nxt = W_IDLE;
        end else if (wr_edge) begin
          state_nxt = W_RST;
          start     = 1'b1;
          drop      = 1'b1;
        end else if (beat_cnt == FRAME_END) begin
          state_nxt = W_DONE;
        end
      end
      W_DONE:  state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  // A beat is forwarded only while the frame is open and not yet full;
  // a beat coinciding with a restart edge is not attributed to either frame.
  assign beat_ok = i_Wr_valid & ((state == W_RST) | (state == W_ACTIVE)) & ~i_Fix_en
                 & (beat_cnt != FRAME_END) & ~wr_edge;

  assign o_Wr_rst  = (state == W_RST);
  assign o_Wr_busy = (state != W_IDLE);

  // Write FSM state register.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= W_IDLE;
    else          state <= state_nxt;
  end

  // Buffer indices, counters and registered outputs.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      latest_idx   <= '0;
      latest_valid <= 1'b0;
      beat_cnt     <= '0;
      rst_cnt      <= '0;
      o_Wr_req     <= 1'b0;
      o_Rd_new     <= 1'b0;
      o_Wr_addr    <= BASE_ADDR;
      o_Rd_addr    <= BASE_ADDR;
    end else begin
      if (start) begin
        wr_idx   <= sel_idx;
        beat_cnt <= '0;
        rst_cnt  <= '0;
      end else begin
        if (beat_ok)         beat_cnt <= beat_cnt + CNT_W'(1);
        if (state == W_RST)  rst_cnt  <= rst_cnt + RC_W'(1);
      end
      if (state == W_DONE) begin
        latest_idx   <= wr_idx;
        latest_valid <= 1'b1;
      end
      rd_idx    <= rd_idx_nxt;
      o_Rd_new  <= rd_edge & (rd_idx_nxt != rd_idx);
      o_Wr_req  <= beat_ok;
      o_Wr_addr <= buf_addr(wr_idx);
      o_Rd_addr <= buf_addr(rd_idx);
    end
  end

`ifdef FBS_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of frames abandoned by a mid-frame sync edge.
  always_ff @(posedge i_Sys_clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
  end

  assign o_Drop_cnt = drop_cnt;
`else
  logic drop_unused;
  assign drop_unused = drop;
  assign o_Drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_frame_buf_scheduler.sv
// Directed self-checking bench for frame_buf_scheduler
// (FRAME_PIXELS=16, RST_PERIOD=4). Honours FBS_DROP_CNT_EN for drop expectations.
module tb_frame_buf_scheduler;

  logic        clk;
  logic        rst_n;
  logic        fix_en;
  logic        wr_vs;
  logic        wr_valid;
  logic        rd_vs;
  logic        wr_rst;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] rd_addr;
  logic        rd_new;
  logic        wr_busy;
  logic [15:0] drop_cnt;

  int n_cmp;
  int n_err;
  int rst_seen;
  int req_seen;
  int new_seen;

`ifdef FBS_DROP_CNT_EN
  localparam logic [15:0] DROP_EXP = 16'd1;
`else
  localparam logic [15:0] DROP_EXP = 16'd0;
`endif

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1010_0000;
  localparam logic [31:0] A2 = 32'h1020_0000;

  frame_buf_scheduler #(
    .AXI_AW       (32),
    .FRAME_PIXELS (16),
    .BASE_ADDR    (32'h1000_0000),
    .FRAME_STRIDE (32'h0010_0000),
    .RST_PERIOD   (4),
    .CNT_W        (5)
  ) dut (
    .i_Sys_clk  (clk),
    .i_Rst_n    (rst_n),
    .i_Fix_en   (fix_en),
    .i_Wr_vs    (wr_vs),
    .i_Wr_valid (wr_valid),
    .i_Rd_vs    (rd_vs),
    .o_Wr_rst   (wr_rst),
    .o_Wr_req   (wr_req),
    .o_Wr_addr  (wr_addr),
    .o_Rd_addr  (rd_addr),
    .o_Rd_new   (rd_new),
    .o_Wr_busy  (wr_busy),
    .o_Drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rst_seen = 0;
    req_seen = 0;
    new_seen = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (wr_rst === 1'b1) rst_seen++;
      if (wr_req === 1'b1) req_seen++;
      if (rd_new === 1'b1) new_seen++;
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clr();
    rst_n = 1'b0; fix_en = 1'b0; wr_vs = 1'b0; wr_valid = 1'b0; rd_vs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Reset state
    chk("rst_wr_addr", wr_addr, A0);
    chk("rst_rd_addr", rd_addr, A0);
    chk("rst_busy", 32'(wr_busy), 32'd0);
    chk("rst_wr_rst", 32'(wr_rst), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rd_new", 32'(rd_new), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // 1: first frame lands in buffer 1 (buffer 0 is the read buffer)
    clr(); wr_vs = 1'b1; wr_valid = 1'b1;
    run(30);
    chk("t1_rst_cycles", 32'(rst_seen), 32'd4);
    chk("t1_req_beats", 32'(req_seen), 32'd16);
    chk("t1_wr_addr", wr_addr, A1);
    chk("t1_idle", 32'(wr_busy), 32'd0);
    wr_vs = 1'b0; wr_valid = 1'b0;
    run(2);

    // 2: read picks buffer 1; next writes go to 0 then 2
    clr(); rd_vs = 1'b1; run(3); rd_vs = 1'b0; run(1);
    chk("t2_rd_addr", rd_addr, A1);
    chk("t2_rd_new", 32'(new_seen), 32'd1);
    clr(); wr_vs = 1'b1; wr_valid = 1'b1; run(30);
    chk("t2_wr_addr_b0", wr_addr, A0);
    wr_vs = 1'b0; wr_valid = 1'b0; run(2);
    clr(); wr_vs = 1'b1; wr_valid = 1'b1; run(30);
    chk("t2_wr_addr_b2", wr_addr, A2);
    chk("t2_req_beats", 32'(req_seen), 32'd16);
    wr_vs = 1'b0; wr_valid = 1'b0; run(2);
    clr(); rd_vs = 1'b1; run(3); rd_vs = 1'b0; run(1);
    chk("t2_rd_addr_b2", rd_addr, A2);
    chk("t2_rd_new_b2", 32'(new_seen), 32'd1);

    // 3: partial frame (8 beats) then a new sync edge drops it
    wr_vs = 1'b1; wr_valid = 1'b1; run(10);
    wr_vs = 1'b0; wr_valid = 1'b0; run(2);
    chk("t3_busy_partial", 32'(wr_busy), 32'd1);
    chk("t3_wr_addr", wr_addr, A0);
    chk("t3_wr_rst_low", 32'(wr_rst), 32'd0);
    chk("t3_drop_before", 32'(drop_cnt), 32'd0);
    wr_vs = 1'b1; run(2);
    chk("t3_restart_rst", 32'(wr_rst), 32'd1);
    chk("t3_drop_after", 32'(drop_cnt), 32'(DROP_EXP));
    run(1);
    chk("t3_restart_addr", wr_addr, A0);
    wr_vs = 1'b0;
    clr(); rd_vs = 1'b1; run(3); rd_vs = 1'b0; run(1);
    chk("t3_rd_new_none", 32'(new_seen), 32'd0);
    chk("t3_rd_addr_hold", rd_addr, A2);

    // 5: freeze mid-frame aborts without a drop and blocks new frames
    wr_valid = 1'b1; run(3);
    chk("t5_req_before", 32'(wr_req), 32'd1);
    fix_en = 1'b1; run(1);
    chk("t5_req_off", 32'(wr_req), 32'd0);
    chk("t5_idle", 32'(wr_busy), 32'd0);
    clr(); wr_vs = 1'b1; run(5);
    chk("t5_busy_frozen", 32'(wr_busy), 32'd0);
    chk("t5_req_frozen", 32'(req_seen), 32'd0);
    chk("t5_rst_frozen", 32'(rst_seen), 32'd0);
    chk("t5_drop_frozen", 32'(drop_cnt), 32'(DROP_EXP));
    fix_en = 1'b0; wr_vs = 1'b0; wr_valid = 1'b0; run(3);
    chk("t5_still_idle", 32'(wr_busy), 32'd0);

    // 4: read sync lands on the W_DONE cycle; buffer 0 is bypassed to read
    clr(); wr_vs = 1'b1; wr_valid = 1'b1; run(18);
    rd_vs = 1'b1; run(1);
    chk("t4_done_busy", 32'(wr_busy), 32'd1);
    run(1);
    chk("t4_after_done", 32'(wr_busy), 32'd0);
    run(1);
    chk("t4_rd_bypass", rd_addr, A0);
    chk("t4_rd_new", 32'(new_seen), 32'd1);
    wr_vs = 1'b0; wr_valid = 1'b0; rd_vs = 1'b0; run(2);
    clr(); wr_vs = 1'b1; wr_valid = 1'b1; run(30);
    chk("t4_next_wr", wr_addr, A1);
    wr_vs = 1'b0; wr_valid = 1'b0; run(2);

    // 6: asynchronous reset mid-W_ACTIVE
    wr_vs = 1'b1; wr_valid = 1'b1; run(8);
    chk("t6_active", 32'(wr_busy), 32'd1);
    chk("t6_req_active", 32'(wr_req), 32'd1);
    #2; rst_n = 1'b0; #1;
    chk("t6_wr_addr", wr_addr, A0);
    chk("t6_rd_addr", rd_addr, A0);
    chk("t6_busy", 32'(wr_busy), 32'd0);
    chk("t6_wr_req", 32'(wr_req), 32'd0);
    chk("t6_wr_rst", 32'(wr_rst), 32'd0);
    chk("t6_rd_new", 32'(rd_new), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
